// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter that shares one transparent D-latch bank between NUM_REQ writers.
// Optional build macro LATCH_ARB_LOCK_EN adds the lock port for back-to-back writes by the granted requester.
module latch_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int EN_CYCLES  = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
`ifdef LATCH_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            lock,
`endif
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         latch_d,
  output logic                          latch_enable,
  output logic                          busy
);

  localparam int PW      = $clog2(NUM_REQ);
  localparam int CNT_MAX = (EN_CYCLES > GAP_CYCLES) ? EN_CYCLES : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] OPEN  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]            r_state;
  logic [PW-1:0]         r_ptr;
  logic [CW-1:0]         r_cnt;
  logic [NUM_REQ-1:0]    r_grant;
  logic [NUM_REQ-1:0]    r_done;
  logic [DATA_WIDTH-1:0] r_d;
  logic                  r_en;

  logic                  w_arb;
  logic                  w_rr_any;
  logic [PW-1:0]         w_rr_win;
  logic                  w_sel_any;
  logic [PW-1:0]         w_sel_idx;

  // Arbitration happens when idle and in the final HOLD cycle, giving gapless back-to-back writes.
  assign w_arb = (r_state == IDLE) || ((r_state == HOLD) && (r_cnt == '0));

  always_comb begin
    int unsigned idx;
    w_rr_any = 1'b0;
    w_rr_win = '0;
    idx      = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(r_ptr) + i) % NUM_REQ;
      if (!w_rr_any && req[idx]) begin
        w_rr_any = 1'b1;
        w_rr_win = PW'(idx);
      end
    end
  end

  always_comb begin
    w_sel_any = w_rr_any;
    w_sel_idx = w_rr_win;
`ifdef LATCH_ARB_LOCK_EN
    // r_ptr always names the current winner, so a locked re-grant leaves it untouched.
    if ((r_state == HOLD) && (r_cnt == '0) && lock[r_ptr] && req[r_ptr]) begin
      w_sel_any = 1'b1;
      w_sel_idx = r_ptr;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ptr   <= PW'(NUM_REQ - 1);
      r_cnt   <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_d     <= '0;
      r_en    <= 1'b0;
    end else begin
      r_done <= '0;
      if (w_arb) begin
        if (w_sel_any) begin
          r_state <= SETUP;
          r_grant <= NUM_REQ'(1) << w_sel_idx;
          r_d     <= data_in[w_sel_idx*DATA_WIDTH +: DATA_WIDTH];
          r_ptr   <= w_sel_idx;
        end else begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      end else begin
        case (r_state)
          SETUP: begin
            r_state <= OPEN;
            r_en    <= 1'b1;
            r_cnt   <= CW'(EN_CYCLES - 1);
          end
          OPEN: begin
            if (r_cnt == '0) begin
              r_state <= HOLD;
              r_en    <= 1'b0;
              r_cnt   <= CW'(GAP_CYCLES - 1);
              if (GAP_CYCLES == 1) r_done <= r_grant;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          HOLD: begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) r_done <= r_grant;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign grant        = r_grant;
  assign done         = r_done;
  assign latch_d      = r_d;
  assign latch_enable = r_en;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Randomized scoreboard bench for latch_write_arbiter; a transaction-phase model predicts each write.
// Build with LATCH_ARB_LOCK_EN defined to also exercise the lock port.
module tb_latch_write_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int EN  = 2;
  localparam int GAP = 1;
  localparam int L   = 1 + EN + GAP;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*DW-1:0]  data_in = '0;
`ifdef LATCH_ARB_LOCK_EN
  logic [NR-1:0]     lock = '0;
`endif
  logic [NR-1:0]     grant, done;
  logic [DW-1:0]     latch_d, q;
  logic              latch_enable, busy;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    int            cyc;
  } txn_t;

  txn_t sb[$];
  int tests = 0, fails = 0, cyc = 0, en_cnt = 0;
  int m_t = -1, m_ptr = NR - 1, m_cur = 0;

  always #5 clk = ~clk;

  latch_write_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .EN_CYCLES(EN), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .data_in(data_in),
`ifdef LATCH_ARB_LOCK_EN
    .lock(lock),
`endif
    .grant(grant), .done(done), .latch_d(latch_d),
    .latch_enable(latch_enable), .busy(busy)
  );

  // Downstream transparent latch
  always_latch if (latch_enable) q <= latch_d;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: each write occupies L cycles; a new winner may be chosen when free.
  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      m_t   = -1;
      m_ptr = NR - 1;
    end else if (m_t < 0 || m_t == L - 1) begin
      int w;
      w = -1;
`ifdef LATCH_ARB_LOCK_EN
      if (m_t == L - 1 && lock[m_cur] && req[m_cur]) w = m_cur;
`endif
      for (int i = 1; i <= NR; i++)
        if (w < 0 && req[(m_ptr + i) % NR]) w = (m_ptr + i) % NR;
      if (w >= 0) begin
        if (w != m_cur || m_t < 0 || !(m_t == L - 1)) m_ptr = w;
        m_cur = w;
        m_ptr = w;
        m_t   = 0;
        sb.push_back('{w, data_in[w*DW +: DW], cyc + L - 1});
      end else begin
        m_t = -1;
      end
    end else begin
      m_t++;
    end
  end

  // Monitor
  always @(negedge clk) begin
    txn_t e;
    if (!reset_n) begin
      en_cnt = 0;
    end else begin
      check("busy", busy, sb.size() != 0);
      if (latch_enable) begin
        en_cnt++;
        if (sb.size() != 0) begin
          check("open_data", latch_d, sb[0].data);
          check("open_grant", grant, 1 << sb[0].idx);
        end else begin
          check("open_without_txn", latch_enable, 0);
        end
      end
      if (done != 0) begin
        if (sb.size() == 0) begin
          check("done_unexpected", done, 0);
        end else begin
          e = sb.pop_front();
          check("done_bit", done, 1 << e.idx);
          check("done_grant", grant, 1 << e.idx);
          check("done_data", latch_d, e.data);
          check("done_cycle", cyc, e.cyc);
          check("open_cycles", en_cnt, EN);
          check("latch_q", q, e.data);
          check("hold_enable", latch_enable, 0);
        end
        en_cnt = 0;
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_busy", busy, 0);
    check("drain_sb", sb.size(), 0);
  endtask

  task automatic wait_open();
    int n = 0;
    while (!latch_enable && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("open_seen", latch_enable, 1);
  endtask

  initial begin
    #1;
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_latch_d", latch_d, 0);
    check("rst_enable", latch_enable, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Single write from requester 2
    @(negedge clk);
    data_in = 32'h00A5_0000;
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    drain();
    check("single_q", q, 8'hA5);

    // Random traffic with data toggling every cycle
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      data_in = $urandom;
      req = (k < 200) ? NR'($urandom) : NR'($urandom & $urandom & $urandom);
`ifdef LATCH_ARB_LOCK_EN
      lock = NR'($urandom);
`endif
    end
    @(negedge clk);
    req = '0;
`ifdef LATCH_ARB_LOCK_EN
    lock = '0;
`endif
    drain();

    // All requesting: round-robin with gapless transactions
    @(negedge clk);
    req = '1;
    for (int k = 0; k < 24; k++) begin
      data_in = $urandom;
      @(negedge clk);
    end
    req = '0;
    drain();

    // Requester 1 drops req mid-write
    @(negedge clk);
    data_in = $urandom;
    req = 4'b0010;
    wait_open();
    req = '0;
    drain();

`ifdef LATCH_ARB_LOCK_EN
    @(negedge clk);
    req = 4'b0011;
    lock = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      data_in = $urandom;
      @(negedge clk);
    end
    lock = '0;
    for (int k = 0; k < 8; k++) begin
      data_in = $urandom;
      @(negedge clk);
    end
    req = '0;
    drain();
`endif

    // Asynchronous reset during OPEN
    @(negedge clk);
    req = 4'b0001;
    wait_open();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_enable", latch_enable, 0);
    check("arst_grant", grant, 0);
    check("arst_busy", busy, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    req = '1;
    for (int k = 0; k < 8; k++) begin
      data_in = $urandom;
      @(negedge clk);
    end
    req = '0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
